// File: rtl/genbus_slave_pkg.sv
// Shared types and constants for the general-bus wait-stated slave.
package genbus_slave_pkg;

  localparam int CNT_W            = 4;
  localparam int STATUS_ID_BYTE   = 0;
  localparam int STATUS_WCNT_BYTE = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } genbus_slave_state_e;

endpackage

// File: rtl/genbus_sram_bytes.sv
// Two-lane byte RAM: combinational read port, synchronous per-lane write port.
module genbus_sram_bytes
  import genbus_slave_pkg::*;
#(
  parameter int DEPTH = 31,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  input  logic [15:0]   wdata,
  input  logic [1:0]    wen,
  output logic [15:0]   rdata
);

  logic [15:0] mem_r [DEPTH];

  // Per-lane byte writes; contents are intentionally never reset.
  always_ff @(posedge clk) begin
    if (wen[0]) mem_r[addr][7:0]  <= wdata[7:0];
    if (wen[1]) mem_r[addr][15:8] <= wdata[15:8];
  end

  // Asynchronous read, zero beyond the populated depth.
  always_comb begin
    rdata = 16'h0000;
    if (int'(addr) < DEPTH) begin
      rdata = mem_r[addr];
    end else begin
      rdata = 16'h0000;
    end
  end

endmodule

// File: rtl/genbus_sram_slave.sv
// General-bus slave: address decode, wait-state FSM, status/wcnt word and
// read multiplexing in front of a two-lane byte RAM.
module genbus_sram_slave
  import genbus_slave_pkg::*;
#(
  parameter int          ID         = 1,
  parameter logic [15:0] BASE_ADR   = 16'h0000,
  parameter int          SIZE_BYTES = 64,
  parameter int          WAITSTATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] adr,
  input  logic [15:0] mdata,
  input  logic [1:0]  we,
  input  logic [1:0]  re,
  output logic [15:0] sdata,
  output logic        ws
);

  localparam int               SW         = $clog2(SIZE_BYTES);
  localparam int               AW         = SW - 1;
  localparam int               WORDS      = SIZE_BYTES / 2;
  localparam logic [AW-1:0]    STATUS_OFF = AW'(WORDS - 1);
  localparam logic [7:0]       ID_BYTE    = 8'(ID);
  localparam logic [CNT_W-1:0] CNT_LOAD   = (WAITSTATES >= 2) ? CNT_W'(WAITSTATES - 2) : '0;

  genbus_slave_state_e state_r, state_nxt_s;
  logic [CNT_W-1:0]    cnt_r, cnt_nxt_s;
  logic [7:0]          wcnt_r;
  logic                hit_s, req_s, is_status_s, complete_s, ws_s;
  logic [AW-1:0]       woff_s;
  logic [1:0]          ram_wen_s;
  logic [15:0]         ram_rdata_s, word_s;
  logic                unused_adr_s;

  // Base is aligned to the window size, so a tag compare is the range check.
  assign hit_s        = (adr[15:SW] == BASE_ADR[15:SW]);
  assign req_s        = hit_s & ((|we) | (|re));
  assign woff_s       = adr[SW-1:1];
  assign is_status_s  = (woff_s == STATUS_OFF);
  assign unused_adr_s = adr[0];

  // State and wait counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= '0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Next-state, stall and completion decode.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    complete_s  = 1'b0;
    ws_s        = 1'b0;
    case (state_r)
      IDLE: begin
        if (!req_s) begin
          state_nxt_s = IDLE;
        end else if (WAITSTATES == 0) begin
          complete_s = 1'b1;
        end else if (WAITSTATES == 1) begin
          ws_s        = 1'b1;
          state_nxt_s = DONE;
        end else begin
          ws_s        = 1'b1;
          cnt_nxt_s   = CNT_LOAD;
          state_nxt_s = WAIT;
        end
      end
      WAIT: begin
        ws_s = 1'b1;
        if (!req_s) begin
          state_nxt_s = IDLE;
        end else if (cnt_r == 4'd0) begin
          state_nxt_s = DONE;
        end else begin
          cnt_nxt_s = cnt_r - 4'd1;
        end
      end
      DONE: begin
        complete_s  = req_s;
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  assign ram_wen_s = {2{complete_s & ~rst & ~is_status_s}} & we;

  genbus_sram_bytes #(
    .DEPTH (WORDS - 1),
    .AW    (AW)
  ) u_bytes (
    .clk   (clk),
    .addr  (woff_s),
    .wdata (mdata),
    .wen   (ram_wen_s),
    .rdata (ram_rdata_s)
  );

  // Write-completion counter; a direct write to its byte beats the increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wcnt_r <= 8'h00;
    end else if (complete_s && is_status_s && we[STATUS_WCNT_BYTE]) begin
      wcnt_r <= mdata[15:8];
    end else if (complete_s && (|we)) begin
      wcnt_r <= wcnt_r + 8'd1;
    end
  end

  assign word_s = is_status_s ? {wcnt_r, ID_BYTE} : ram_rdata_s;
  assign ws     = ws_s & ~rst;

  // Lane-masked read data, only during a completion cycle.
  always_comb begin
    sdata = 16'h0000;
    if (complete_s && !rst) begin
      sdata[7:0]  = re[0] ? word_s[7:0]  : 8'h00;
      sdata[15:8] = re[1] ? word_s[15:8] : 8'h00;
    end else begin
      sdata = 16'h0000;
    end
  end

endmodule

// File: tb/tb_genbus_sram_slave.sv
// Directed bench: three slaves (WAITSTATES 3, 2, 0) on separate buses, shared clock/reset.
module tb_genbus_sram_slave;

  logic             clk = 1'b0;
  logic             rst;
  logic [2:0][15:0] adr_v, mdata_v, sdata_v;
  logic [2:0][1:0]  we_v, re_v;
  logic [2:0]       ws_v;
  int               n_cmp = 0;
  int               n_err = 0;
  logic [15:0]      rd;
  int               nws;

  always #5 clk = ~clk;

  genbus_sram_slave #(.ID(1), .BASE_ADR(16'h0100), .SIZE_BYTES(64), .WAITSTATES(3)) dut_ws3 (
    .clk(clk), .rst(rst), .adr(adr_v[0]), .mdata(mdata_v[0]), .we(we_v[0]), .re(re_v[0]),
    .sdata(sdata_v[0]), .ws(ws_v[0]));

  genbus_sram_slave #(.ID(8'h5A), .BASE_ADR(16'h0100), .SIZE_BYTES(64), .WAITSTATES(2)) dut_ws2 (
    .clk(clk), .rst(rst), .adr(adr_v[1]), .mdata(mdata_v[1]), .we(we_v[1]), .re(re_v[1]),
    .sdata(sdata_v[1]), .ws(ws_v[1]));

  genbus_sram_slave #(.ID(1), .BASE_ADR(16'h0100), .SIZE_BYTES(64), .WAITSTATES(0)) dut_ws0 (
    .clk(clk), .rst(rst), .adr(adr_v[2]), .mdata(mdata_v[2]), .we(we_v[2]), .re(re_v[2]),
    .sdata(sdata_v[2]), .ws(ws_v[2]));

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One complete access: counts stall cycles, samples sdata in the completion cycle.
  task automatic do_acc(input int i, input logic [15:0] a, input logic [15:0] d,
                        input logic [1:0] w, input logic [1:0] r,
                        output logic [15:0] data, output int stalls);
    @(negedge clk);
    adr_v[i] = a; mdata_v[i] = d; we_v[i] = w; re_v[i] = r;
    stalls = 0;
    #1;
    while (ws_v[i] === 1'b1 && stalls < 20) begin
      stalls++;
      @(negedge clk);
      #1;
    end
    data = sdata_v[i];
    @(negedge clk);
    we_v[i] = 2'b00; re_v[i] = 2'b00; adr_v[i] = 16'h0000;
  endtask

  initial begin
    rst = 1'b1;
    adr_v = '0; mdata_v = '0; we_v = '0; re_v = '0;
    repeat (2) @(negedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      check("reset_ws", {15'h0000, ws_v[i]}, 16'h0000);
      check("reset_sdata", sdata_v[i], 16'h0000);
    end
    @(negedge clk);
    rst = 1'b0;

    // WAITSTATES=3: seed offset 2, then reset in the middle of a second write
    do_acc(0, 16'h0104, 16'h1111, 2'b11, 2'b00, rd, nws);
    check("ws3_write_stall", 16'(nws), 16'd3);
    do_acc(0, 16'h0104, 16'h0000, 2'b00, 2'b11, rd, nws);
    check("ws3_seed_read", rd, 16'h1111);
    @(negedge clk);
    adr_v[0] = 16'h0104; mdata_v[0] = 16'hA500; we_v[0] = 2'b11;
    #1;
    check("ws3_stall_start", {15'h0000, ws_v[0]}, 16'h0001);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid_wait_ws", {15'h0000, ws_v[0]}, 16'h0000);
    check("rst_mid_wait_sdata", sdata_v[0], 16'h0000);
    @(negedge clk);
    we_v[0] = 2'b00; adr_v[0] = 16'h0000;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_release_ws", {15'h0000, ws_v[0]}, 16'h0000);
    check("rst_release_sdata", sdata_v[0], 16'h0000);
    do_acc(0, 16'h013E, 16'h0000, 2'b00, 2'b11, rd, nws);
    check("rst_wcnt_cleared", rd, 16'h0001);
    do_acc(0, 16'h0104, 16'h0000, 2'b00, 2'b11, rd, nws);
    check("rst_ram_kept", rd, 16'h1111);

    // WAITSTATES=2, ID=8'h5A: full write, lane writes, status word
    do_acc(1, 16'h013E, 16'h0000, 2'b00, 2'b11, rd, nws);
    check("ws2_status_init", rd, 16'h005A);
    do_acc(1, 16'h0104, 16'hBEEF, 2'b11, 2'b00, rd, nws);
    check("ws2_write_stall", 16'(nws), 16'd2);
    do_acc(1, 16'h0104, 16'h0000, 2'b00, 2'b11, rd, nws);
    check("ws2_read_stall", 16'(nws), 16'd2);
    check("ws2_read_beef", rd, 16'hBEEF);
    do_acc(1, 16'h013E, 16'h0000, 2'b00, 2'b11, rd, nws);
    check("ws2_wcnt_1", rd, 16'h015A);
    do_acc(1, 16'h0104, 16'h1234, 2'b01, 2'b00, rd, nws);
    do_acc(1, 16'h0104, 16'h0000, 2'b00, 2'b11, rd, nws);
    check("lane_even_write", rd, 16'hBE34);
    do_acc(1, 16'h0104, 16'h0000, 2'b00, 2'b10, rd, nws);
    check("lane_odd_read", rd, 16'hBE00);
    do_acc(1, 16'h013E, 16'hFF00, 2'b11, 2'b00, rd, nws);
    do_acc(1, 16'h013E, 16'h0000, 2'b00, 2'b11, rd, nws);
    check("status_write_wcnt_ff", rd, 16'hFF5A);
    do_acc(1, 16'h0106, 16'h0001, 2'b11, 2'b00, rd, nws);
    do_acc(1, 16'h013E, 16'h0000, 2'b00, 2'b11, rd, nws);
    check("wcnt_wrap", rd, 16'h005A);
    do_acc(1, 16'h0104, 16'h7788, 2'b11, 2'b11, rd, nws);
    check("rw_same_lane_prewrite", rd, 16'hBE34);
    do_acc(1, 16'h0104, 16'h0000, 2'b00, 2'b11, rd, nws);
    check("rw_same_lane_commit", rd, 16'h7788);

    // Abort: drop strobes during WAIT
    @(negedge clk);
    adr_v[1] = 16'h0104; mdata_v[1] = 16'hDEAD; we_v[1] = 2'b11;
    #1;
    check("abort_stall_start", {15'h0000, ws_v[1]}, 16'h0001);
    @(negedge clk);
    we_v[1] = 2'b00;
    repeat (2) @(negedge clk);
    adr_v[1] = 16'h0000;
    do_acc(1, 16'h0104, 16'h0000, 2'b00, 2'b11, rd, nws);
    check("abort_no_write", rd, 16'h7788);
    do_acc(1, 16'h013E, 16'h0000, 2'b00, 2'b11, rd, nws);
    check("abort_wcnt_same", rd, 16'h015A);

    // Misses above and below the window
    @(negedge clk);
    adr_v[1] = 16'h0200; mdata_v[1] = 16'h5555; we_v[1] = 2'b11; re_v[1] = 2'b11;
    #1;
    check("miss_above_ws", {15'h0000, ws_v[1]}, 16'h0000);
    check("miss_above_sdata", sdata_v[1], 16'h0000);
    @(negedge clk);
    adr_v[1] = 16'h00FE;
    #1;
    check("miss_below_ws", {15'h0000, ws_v[1]}, 16'h0000);
    check("miss_below_sdata", sdata_v[1], 16'h0000);
    @(negedge clk);
    we_v[1] = 2'b00; re_v[1] = 2'b00; adr_v[1] = 16'h0000;
    do_acc(1, 16'h013E, 16'h0000, 2'b00, 2'b11, rd, nws);
    check("miss_wcnt_same", rd, 16'h015A);

    // WAITSTATES=0: back-to-back writes then back-to-back reads
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      adr_v[2] = 16'h0100 + 16'(2 * k); mdata_v[2] = 16'hC000 + 16'(k * 16'h0111);
      we_v[2] = 2'b11; re_v[2] = 2'b00;
      #1;
      check("ws0_write_nostall", {15'h0000, ws_v[2]}, 16'h0000);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      adr_v[2] = 16'h0100 + 16'(2 * k); we_v[2] = 2'b00; re_v[2] = 2'b11;
      #1;
      check("ws0_read_nostall", {15'h0000, ws_v[2]}, 16'h0000);
      check("ws0_read_data", sdata_v[2], 16'hC000 + 16'(k * 16'h0111));
    end
    @(negedge clk);
    re_v[2] = 2'b00; adr_v[2] = 16'h0000;
    do_acc(2, 16'h013E, 16'h0000, 2'b00, 2'b11, rd, nws);
    check("ws0_wcnt_4", rd, 16'h0401);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/genbus_sram_slave.md
# genbus_sram_slave

Wait-stated byte-lane data RAM that sits on the slave side of the general bus, directly downstream of the CPU data-bus master. It decodes the master's address, write-strobe and read-strobe signals and stalls the master through `ws` for a configurable number of cycles. It then commits writes or returns read data on `sdata`. The top word of its window is a control/status word holding the slave ID and a write-completion counter.

## Interface
Parameters:
- `ID`, 1: slave identifier; its low byte is returned read-only at status byte 0.
- `BASE_ADR`, 16'h0000: first byte address of the window; must be a multiple of `SIZE_BYTES`.
- `SIZE_BYTES`, 64: window size in bytes; a power of two in the range 8..256.
- `WAITSTATES`, 1: number of cycles `ws` is held high per access; range 0..15.

Ports:
- `clk`, in, 1: clock; all state updates on the rising edge.
- `rst`, in, 1: reset; **asynchronous, active-high**.
- `adr`, in, 16: byte address; `adr[0]` is ignored because accesses are word-aligned.
- `mdata`, in, 16: write data; `[7:0]` is the even byte and `[15:8]` is the odd byte.
- `we`, in, 2: per-lane write strobes; `we[0]` selects the even byte, `we[1]` the odd byte.
- `re`, in, 2: per-lane read strobes; same lane mapping as `we`.
- `sdata`, out, 16: read data.
- `ws`, out, 1: wait state; while it is 1 the master must hold its request stable.

## Operation
- Hit and request:
  - `hit` = `adr` lies within [BASE_ADR, BASE_ADR+SIZE_BYTES).
  - `req` = `hit & (|we | |re)`.
- Word offset: `woff` = (`adr`−BASE_ADR) >> 1.
- Address map:
  - The RAM covers word offsets 0..SIZE_BYTES/2−2.
  - The last word offset is the status word:
    - Byte 0 = `ID[7:0]`, read-only; writes to it are ignored.
    - Byte 1 = `wcnt`, an 8-bit counter. Software may write it.
- `wcnt` update:
  - It increments by 1 on every completed access with any `we` bit set, excluding writes to status byte 1.
  - It wraps from 8'hFF to 8'h00.
  - When a status byte-1 write and an increment would occur on the same edge, the write wins.
- FSM states are IDLE, WAIT and DONE. `cnt` is a 4-bit counter.
- IDLE:
  - If `!req`, stay in IDLE.
  - If `req` and WAITSTATES==0, the access completes this cycle and the FSM stays in IDLE.
  - If `req` and WAITSTATES==1, go to DONE.
  - If `req` and WAITSTATES≥2, load `cnt` with WAITSTATES−2 and go to WAIT.
- WAIT:
  - If `!req`, abort: go to IDLE with no write and no `wcnt` change.
  - Else if `cnt`==0, go to DONE.
  - Else decrement `cnt`.
- DONE:
  - The access completes this cycle; next state is IDLE.
  - If `!req` in DONE, nothing is committed.
- `ws` is combinational:
  - `ws` = (IDLE & `req` & WAITSTATES≠0) | WAIT.
  - `ws` is 0 in DONE and 0 on a miss.
- Completion:
  - Writes are committed on the clock edge ending the completion cycle, per lane with `we` set.
  - `sdata` is valid (combinational) during the completion cycle. Lanes with `re` set carry the addressed byte; other lanes read 0.
  - Outside a completion cycle, `sdata` = 16'h0000.
- Simultaneous `we` and `re` on the same lane: `sdata` returns the pre-write value, and the write still commits.
- Miss: `ws`=0, `sdata`=0, no state change.
- Reset (asserted at any time, including mid-WAIT):
  - Resets the FSM to IDLE, `cnt` to 0 and `wcnt` to 0.
  - The pending access is dropped.
  - RAM contents are not reset.

## Timing
- Reset values of outputs: `ws`=0, `sdata`=16'h0000.
- Latency: `ws` is high for exactly WAITSTATES consecutive cycles, starting in the cycle `req` first appears. The completion cycle follows immediately.
- WAITSTATES=0 gives single-cycle accesses with zero stall; back-to-back accesses complete every cycle.
- WAITSTATES≥1: the cycle after DONE is IDLE. A `req` still present there starts a new access, so the minimum access period is WAITSTATES+1 cycles.
- Changing `adr`, `we`, `re` or `mdata` while `ws`=1 is a protocol violation. The only exceptions are dropping all strobes or moving `adr` outside the window, which aborts the access as defined above.

## Structure
- Package `genbus_slave_pkg` contains:
  - `genbus_slave_state_e` (IDLE, WAIT, DONE);
  - the localparams STATUS_ID_BYTE=0 and STATUS_WCNT_BYTE=1;
  - the `cnt` width constant of 4.
- Sub-module `genbus_sram_bytes` is a two-lane byte RAM with:
  - depth SIZE_BYTES/2−1 words;
  - a combinational read port and a synchronous per-lane write port.
- The top module holds the decode, the FSM, `wcnt` and the read multiplexing.

## Test plan
- Reset mid-WAIT with WAITSTATES=3, then a write of word 8'h00/8'hA5 at offset 2 → after release, `ws`=0, `sdata`=0, `wcnt`=0, and the previous RAM contents at offset 2 are unchanged.
- WAITSTATES=2: write `mdata`=16'hBEEF with `we`=2'b11 at BASE+4 → `ws` high for 2 cycles, commit in the DONE cycle. A later read with `re`=2'b11 returns 16'hBEEF, and `wcnt` goes from 0 to 1.
- Lane test: `we`=2'b01 with 16'h1234 over stored 16'hBEEF → a full read returns 16'hBE34. A read with `re`=2'b10 returns 16'hBE00.
- Status word with `ID`=8'h5A: a read returns {`wcnt`, 8'h5A}. Writing 16'hFF00 sets `wcnt` to 8'hFF and leaves the ID unchanged. One further RAM write wraps `wcnt` to 8'h00.
- Abort and miss: drop `we` during WAIT → no write and no `wcnt` change. An address outside the window → `ws`=0 and `sdata`=0.
- WAITSTATES=0: reads issued every cycle to consecutive words → `ws` is never 1, and data matches each address in the same cycle.
